// File: rtl/mem_map_ctrl.sv
// mem_map_ctrl: decodes one core load/store into ROM, RAM or GPIO, rebases the address and inserts wait states.
// Latency: req to ready is the region's WS + 2 cycles; the minimum back-to-back period is WS + 3.
// Backpressure: the core holds req/addr/we/wd until the ready pulse; req is ignored while an access is in flight.
// Optional feature macro: BUS_ERR_EN (err reporting for unmapped/illegal accesses; undefined = err tied 0).
module mem_map_ctrl #(
    parameter int          AW        = 32,
    parameter int          DW        = 32,
    parameter int unsigned ROM_WORDS = 152100,
    parameter int unsigned RAM_BASE  = 152100,
    parameter int unsigned RAM_WORDS = 152356,
    parameter int unsigned GPIO_ADDR = 304456,
    parameter int          GPIO_W    = 8,
    parameter int unsigned ROM_WS    = 1,
    parameter int unsigned RAM_WS    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     wd,
    output logic              ready,
    output logic [DW-1:0]     rd,
    output logic              err,
    output logic [AW-1:0]     rom_addr,
    input  logic [DW-1:0]     rom_rd,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_wd,
    output logic              ram_we,
    input  logic [DW-1:0]     ram_rd,
    output logic [GPIO_W-1:0] gpio,
    output logic              gpio_en
);

    // Region bounds in address-width arithmetic; ROM_END is exclusive, RAM_HI inclusive.
    localparam logic [AW-1:0] ROM_END = AW'(ROM_WORDS);
    localparam logic [AW-1:0] RAM_LO  = AW'(RAM_BASE);
    localparam logic [AW-1:0] RAM_HI  = AW'(RAM_BASE + RAM_WORDS - 1);
    localparam logic [AW-1:0] GPIO_A  = AW'(GPIO_ADDR);
    localparam logic [3:0]    ROM_WS4 = 4'(ROM_WS);
    localparam logic [3:0]    RAM_WS4 = 4'(RAM_WS);

    // Overlapping regions would make the decode priority silently hide part of a device.
    if ((RAM_BASE < ROM_WORDS) || (GPIO_ADDR < ROM_WORDS) ||
        ((GPIO_ADDR >= RAM_BASE) && (GPIO_ADDR <= RAM_BASE + RAM_WORDS - 1))) begin : g_overlap
        $error("mem_map_ctrl: ROM, RAM and GPIO regions overlap");
    end

    typedef enum logic [1:0] {
        REG_ROM,
        REG_RAM,
        REG_GPIO,
        REG_NONE
    } region_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    // The part of the request that must survive until the access completes.
    typedef struct packed {
        logic          we;
        logic [DW-1:0] wd;
        region_t       region;
    } lat_t;

    state_t        state;
    logic [3:0]    cnt;
    lat_t          lat;
    region_t       dec;
    logic [DW-1:0] rd_nxt;

`ifdef BUS_ERR_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign ram_wd = lat.wd;

    function automatic logic [3:0] ws_of(input region_t r);
        case (r)
            REG_ROM: ws_of = ROM_WS4;
            REG_RAM: ws_of = RAM_WS4;
            default: ws_of = 4'd0;
        endcase
    endfunction

    // Address decode with priority ROM, RAM, GPIO; anything else is unmapped.
    always_comb begin
        dec = REG_NONE;
        if (addr < ROM_END) begin
            dec = REG_ROM;
        end else if ((addr >= RAM_LO) && (addr <= RAM_HI)) begin
            dec = REG_RAM;
        end else if (addr == GPIO_A) begin
            dec = REG_GPIO;
        end
    end

    // Read-data source for the latched region, sampled on the last wait cycle.
    always_comb begin
        rd_nxt = rom_rd;
        case (lat.region)
            REG_RAM:  rd_nxt = ram_rd;
            REG_GPIO: rd_nxt = DW'(gpio);
`ifdef BUS_ERR_EN
            REG_NONE: rd_nxt = '0;
`else
            REG_NONE: rd_nxt = rom_rd;
`endif
            default:  rd_nxt = rom_rd;
        endcase
    end

    // Access FSM: latch in IDLE, count wait states, complete and commit writes in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            lat      <= '0;
            ready    <= 1'b0;
            rd       <= '0;
            ram_we   <= 1'b0;
            gpio     <= '0;
            gpio_en  <= 1'b0;
            rom_addr <= '0;
            ram_addr <= '0;
`ifdef BUS_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            ready   <= 1'b0;
            ram_we  <= 1'b0;
            gpio_en <= 1'b0;
`ifdef BUS_ERR_EN
            err_q   <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (req) begin
                        lat.we     <= we;
                        lat.wd     <= wd;
                        lat.region <= dec;
                        // Unmapped accesses point the ROM at word 0 so a fallback read is defined.
                        rom_addr   <= (dec == REG_ROM) ? addr : '0;
                        ram_addr   <= (dec == REG_RAM) ? (addr - RAM_LO) : '0;
                        cnt        <= ws_of(dec);
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_DONE;
                        ready <= 1'b1;
                        if (!lat.we) begin
                            rd <= rd_nxt;
                        end
                        if (lat.we && (lat.region == REG_RAM)) begin
                            ram_we <= 1'b1;
                        end
                        if (lat.we && (lat.region == REG_GPIO)) begin
                            gpio    <= lat.wd[GPIO_W-1:0];
                            gpio_en <= 1'b1;
                        end
`ifdef BUS_ERR_EN
                        err_q <= (lat.region == REG_NONE) ||
                                 (lat.we && (lat.region == REG_ROM));
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_map_ctrl.sv
// Scoreboard bench for mem_map_ctrl: directed accesses push expected completions,
// a negedge monitor pops and compares on ready, ram_we and gpio_en.
module tb_mem_map_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wd = '0;
    logic        ready;
    logic [31:0] rd;
    logic        err;
    logic [31:0] rom_addr;
    logic [31:0] rom_rd;
    logic [31:0] ram_addr;
    logic [31:0] ram_wd;
    logic        ram_we;
    logic [31:0] ram_rd;
    logic [7:0]  gpio;
    logic        gpio_en;

    mem_map_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wd(wd),
        .ready(ready), .rd(rd), .err(err),
        .rom_addr(rom_addr), .rom_rd(rom_rd),
        .ram_addr(ram_addr), .ram_wd(ram_wd), .ram_we(ram_we), .ram_rd(ram_rd),
        .gpio(gpio), .gpio_en(gpio_en)
    );

    always #5 clk = ~clk;

    // ROM content: word n holds 0xC0DE0000 + n.
    assign rom_rd = 32'hC0DE_0000 + rom_addr;

    logic [31:0] ram_mem [0:255];
    assign ram_rd = ram_mem[ram_addr[7:0]];
    always @(posedge clk) if (ram_we) ram_mem[ram_addr[7:0]] <= ram_wd;

    typedef struct {
        logic [31:0] rd;
        bit          crd;
        bit          err;
        int          cyc;
        int          rom_a;
        int          ram_a;
    } exp_t;
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         wr_q[$];
    logic [7:0]  gp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          we_seen = 0;
    logic        prev_ready = 1'b0;
    logic        prev_we = 1'b0;
    logic        prev_gen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req_v);
        end
    endtask

    // Monitor: compare every completion and side-effect pulse against the queues.
    always @(negedge clk) begin
        exp_t e;
        wr_t w;
        logic [7:0] g;
        if (ready === 1'b1) begin
            check("ready_pulse", 32'(prev_ready), 32'd0);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready actual=1 required=0");
            end else begin
                e = exp_q.pop_front();
                check("latency", cyc, e.cyc);
                if (e.crd) check("rd", rd, e.rd);
                check("err", 32'(err), 32'(e.err));
                if (e.rom_a >= 0) check("rom_addr", rom_addr, e.rom_a);
                if (e.ram_a >= 0) check("ram_addr", ram_addr, e.ram_a);
            end
        end
        if (ram_we === 1'b1) begin
            we_seen++;
            check("ram_we_pulse", 32'(prev_we), 32'd0);
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ram_we actual=1 required=0");
            end else begin
                w = wr_q.pop_front();
                check("ram_we_addr", ram_addr, w.a);
                check("ram_we_data", ram_wd, w.d);
            end
        end
        if (gpio_en === 1'b1) begin
            check("gpio_en_pulse", 32'(prev_gen), 32'd0);
            if (gp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_gpio_en actual=1 required=0");
            end else begin
                g = gp_q.pop_front();
                check("gpio_val", 32'(gpio), 32'(g));
            end
        end
        prev_ready = (ready === 1'b1);
        prev_we    = (ram_we === 1'b1);
        prev_gen   = (gpio_en === 1'b1);
    end

    // One access: present it, queue the expected completion, wait (bounded) for ready.
    // b2b=1 presents the request in the ready cycle of the previous access.
    task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] erd, input bit crd, input bit eerr,
                       input int ws, input bit b2b, input int rom_a, input int ram_a);
        exp_t e;
        int n;
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        req = 1'b1; we = w; addr = a; wd = d;
        e.rd = erd; e.crd = crd; e.err = eerr;
        e.cyc = (b2b ? cyc + 1 : cyc) + ws + 2;
        e.rom_a = rom_a; e.ram_a = ram_a;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((ready !== 1'b1) && (n < 50));
        check("ready_seen", 32'(ready), 32'd1);
        req = 1'b0; we = 1'b0;
    endtask

    initial begin
        int snap;
        logic [31:0] unm_rd;
        bit unm_err;
        for (int i = 0; i < 256; i++) ram_mem[i] = '0;
`ifdef BUS_ERR_EN
        unm_rd = 32'h0;
        unm_err = 1'b1;
`else
        unm_rd = 32'hC0DE_0000;
        unm_err = 1'b0;
`endif
        // Reset state.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rd", rd, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_gpio", 32'(gpio), 32'd0);
        check("rst_gpio_en", 32'(gpio_en), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_rom_addr", rom_addr, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);

        // Give gpio a nonzero value so its clearing by reset is visible.
        gp_q.push_back(8'h5A);
        acc(1'b1, 32'd304456, 32'h5A, 32'h0, 1'b1, 1'b0, 0, 1'b0, -1, -1);

        // RAM write interrupted by a 3-cycle reset while in WAIT: no ram_we, gpio cleared.
        @(posedge clk);
        #1;
        snap = we_seen;
        req = 1'b1; we = 1'b1; addr = 32'd152100; wd = 32'h1111_1111;
        @(posedge clk);
        #1;
        rst = 1'b1; req = 1'b0; we = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_gpio", 32'(gpio), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_ram_we", we_seen, snap);

        // ROM boundary read, one wait state.
        acc(1'b0, 32'd152099, 32'h0, 32'hC0E0_5223, 1'b1, 1'b0, 1, 1'b0, 152099, -1);
        // RAM first word write then back-to-back read; rd holds across the write.
        wr_q.push_back('{32'd0, 32'hDEAD_BEEF});
        acc(1'b1, 32'd152100, 32'hDEAD_BEEF, 32'hC0E0_5223, 1'b1, 1'b0, 0, 1'b0, -1, 0);
        acc(1'b0, 32'd152100, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 0, 1'b1, -1, 0);
        // RAM last word.
        wr_q.push_back('{32'd152355, 32'hCAFE_F00D});
        acc(1'b1, 32'd304455, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b1, 1'b0, 0, 1'b1, -1, 152355);
        acc(1'b0, 32'd304455, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0, 0, 1'b1, -1, 152355);
        // GPIO write truncates to 8 bits; readback zero-extends.
        gp_q.push_back(8'hA5);
        acc(1'b1, 32'd304456, 32'h1A5, 32'hCAFE_F00D, 1'b1, 1'b0, 0, 1'b1, -1, -1);
        acc(1'b0, 32'd304456, 32'h0, 32'h0000_00A5, 1'b1, 1'b0, 0, 1'b1, -1, -1);
        // Unmapped read just past GPIO.
        acc(1'b0, 32'd304457, 32'h0, unm_rd, 1'b1, unm_err, 0, 1'b1, 0, -1);
        // ROM write and unmapped write: no side effects, rd unchanged.
        acc(1'b1, 32'd7, 32'h1234_5678, unm_rd, 1'b1, unm_err, 1, 1'b1, 7, -1);
        acc(1'b1, 32'hFFFF_FFFF, 32'h77, unm_rd, 1'b1, unm_err, 0, 1'b1, 0, -1);
        check("gpio_kept", 32'(gpio), 32'hA5);
        // ROM word 0 and an unwritten RAM word.
        acc(1'b0, 32'd0, 32'h0, 32'hC0DE_0000, 1'b1, 1'b0, 1, 1'b1, 0, -1);
        acc(1'b0, 32'd152101, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1'b0, -1, 1);

        repeat (5) @(posedge clk);
        #1;
        check("exp_q_empty", exp_q.size(), 32'd0);
        check("wr_q_empty", wr_q.size(), 32'd0);
        check("gp_q_empty", gp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
